fir_tap_sequencer: RTL and testbench

Control sequencer for the 16-tap FIR filter's single shared multiply-accumulate (MAC) datapath. It accepts one input sample per valid/ready handshake and writes it into the circular sample delay line. It then walks all taps, issuing sample and coefficient addresses and MAC strobes. After the MAC pipeline drains, it holds `out_valid` until the output is taken. The delay-line RAM, coefficient ROM and MAC/accumulator are external.

---
 rtl/fir_tap_sequencer.sv | 165 ++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer.sv
// Tap sequencer for a 16-tap FIR filter sharing one external MAC datapath.
// Optional build macro FIR_SYMMETRIC_EN folds symmetric taps into N/2 MAC cycles.
module fir_tap_sequencer #(
    parameter int NTAPS   = 16,
    parameter int AW      = 4,
    parameter int MAC_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic          wr_zero,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic [AW-1:0] coef_addr,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          mac_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);

    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [2:0] ST_CLEAR = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_MAC   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;

    localparam logic [AW-1:0] LAST_SLOT  = AW'(NTAPS - 1);
`ifdef FIR_SYMMETRIC_EN
    localparam logic [AW-1:0] LAST_TAP   = AW'(NTAPS / 2 - 1);
`else
    localparam logic [AW-1:0] LAST_TAP   = AW'(NTAPS - 1);
`endif
    localparam logic [DW-1:0] LAST_DRAIN = DW'(MAC_LAT - 1);

    logic [2:0]    state_q,    state_d;
    logic [AW-1:0] head_q,     head_d;
    logic [AW-1:0] newest_q,   newest_d;
    logic [AW-1:0] tapCnt_q,   tapCnt_d;
    logic [DW-1:0] drainCnt_q, drainCnt_d;

    // The tap counter doubles as the zero-fill address during CLEAR.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        newest_d   = newest_q;
        tapCnt_d   = tapCnt_q;
        drainCnt_d = drainCnt_q;
        case (state_q)
            ST_CLEAR: begin
                tapCnt_d = tapCnt_q + 1'b1;
                if (tapCnt_q == LAST_SLOT) begin
                    tapCnt_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (in_valid) begin
                    newest_d = head_q;
                    head_d   = head_q + 1'b1;
                    tapCnt_d = '0;
                    state_d  = ST_MAC;
                end
            end
            ST_MAC: begin
                tapCnt_d = tapCnt_q + 1'b1;
                if (tapCnt_q == LAST_TAP) begin
                    tapCnt_d   = '0;
                    drainCnt_d = '0;
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drainCnt_d = drainCnt_q + 1'b1;
                if (drainCnt_q == LAST_DRAIN) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tapCnt_d = '0;
                state_d  = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            head_q     <= '0;
            newest_q   <= '0;
            tapCnt_q   <= '0;
            drainCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            newest_q   <= newest_d;
            tapCnt_q   <= tapCnt_d;
            drainCnt_q <= drainCnt_d;
        end
    end

    // Outputs are forced low while reset is held, whatever state was left behind.
    always_comb begin
        in_ready  = 1'b0;
        wr_en     = 1'b0;
        wr_zero   = 1'b0;
        wr_addr   = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        coef_addr = '0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        mac_last  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_CLEAR: begin
                    busy    = 1'b1;
                    wr_en   = 1'b1;
                    wr_zero = 1'b1;
                    wr_addr = tapCnt_q;
                end
                ST_IDLE: begin
                    in_ready = 1'b1;
                    wr_en    = in_valid;
                    wr_addr  = head_q;
                end
                ST_MAC: begin
                    busy      = 1'b1;
                    mac_en    = 1'b1;
                    coef_addr = tapCnt_q;
                    rd_addr_a = newest_q - tapCnt_q;
`ifdef FIR_SYMMETRIC_EN
                    rd_addr_b = newest_q - (LAST_SLOT - tapCnt_q);
`endif
                    mac_clr   = (tapCnt_q == '0);
                    mac_last  = (tapCnt_q == LAST_TAP);
                end
                ST_DRAIN: begin
                    busy = 1'b1;
                end
                ST_OUT: begin
                    busy      = 1'b1;
                    out_valid = 1'b1;
                end
                default: begin
                    busy = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Randomized scoreboard bench for fir_tap_sequencer; honours FIR_SYMMETRIC_EN like the design.
module tb_fir_tap_sequencer;

    localparam int NTAPS   = 16;
    localparam int AW      = 4;
    localparam int MAC_LAT = 2;
`ifdef FIR_SYMMETRIC_EN
    localparam int NMAC = NTAPS / 2;
`else
    localparam int NMAC = NTAPS;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, wr_en, wr_zero, mac_clr, mac_en, mac_last, out_valid, busy;
    logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b, coef_addr;

    fir_tap_sequencer #(.NTAPS(NTAPS), .AW(AW), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_zero(wr_zero), .wr_addr(wr_addr),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .coef_addr(coef_addr),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_last(mac_last),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; int addr; bit zero;} wr_t;
    typedef struct {int cyc; int a; int b; int coef; bit clr; bit last;} mac_t;

    wr_t  wrQ[$];
    mac_t macQ[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    int   readyFrom = -1;
    int   outFrom = -1;
    int   head = 0;
    int   lastAccept = -1;
    bit   expIR = 1'b0;
    bit   expOV = 1'b0;
    bit   inRst = 1'b1;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit iv, input bit ordy, input bit r, input int n);
        @(posedge clk);
        #1;
        in_valid  = iv;
        out_ready = ordy;
        rst       = r;
        repeat (n - 1) @(posedge clk);
    endtask

    // Reference model: tracks timing only through cycle stamps (when the
    // sequencer becomes ready, when a result appears) and queues the exact
    // write and MAC events each accepted sample or reset must produce.
    always @(negedge clk) begin
        int nw;
        inRst = rst;
        if (rst) begin
            wrQ.delete();
            macQ.delete();
            head      = 0;
            outFrom   = -1;
            readyFrom = cyc + 1 + NTAPS;
            expIR     = 1'b0;
            expOV     = 1'b0;
            for (int k = 0; k < NTAPS; k++) wrQ.push_back('{cyc + 1 + k, k, 1'b1});
        end else begin
            expIR = (readyFrom >= 0) && (cyc >= readyFrom);
            expOV = (outFrom >= 0) && (cyc >= outFrom);
            if (expIR && in_valid) begin
                nw = head;
                wrQ.push_back('{cyc, nw, 1'b0});
                head = (head + 1) % NTAPS;
                for (int k = 0; k < NMAC; k++) begin
                    mac_t m;
                    m.cyc  = cyc + 1 + k;
                    m.a    = (nw - k + NTAPS) % NTAPS;
`ifdef FIR_SYMMETRIC_EN
                    m.b    = (nw - (NTAPS - 1 - k) + NTAPS) % NTAPS;
`else
                    m.b    = 0;
`endif
                    m.coef = k;
                    m.clr  = (k == 0);
                    m.last = (k == NMAC - 1);
                    macQ.push_back(m);
                end
                outFrom    = cyc + 1 + NMAC + MAC_LAT;
                readyFrom  = -1;
                lastAccept = cyc;
            end
            if (expOV && out_ready) begin
                outFrom   = -1;
                readyFrom = cyc + 1;
            end
        end
    end

    // Monitor: compares DUT outputs against the model's expectations and pops
    // queued events in the cycle they are due.
    always @(negedge clk) begin
        bit   ew, em;
        wr_t  w;
        mac_t m;
        #1;
        if (inRst) begin
            checkOutput("reset_outputs",
                        int'({in_ready, wr_en, wr_zero, wr_addr, rd_addr_a, rd_addr_b,
                              coef_addr, mac_clr, mac_en, mac_last, out_valid, busy}), 0);
        end else begin
            checkOutput("in_ready", int'(in_ready), int'(expIR));
            checkOutput("out_valid", int'(out_valid), int'(expOV));
            checkOutput("busy", int'(busy), int'(!expIR));
            ew = (wrQ.size() > 0) && (wrQ[0].cyc == cyc);
            checkOutput("wr_en", int'(wr_en), int'(ew));
            if (ew) begin
                w = wrQ.pop_front();
                if (wr_en) begin
                    checkOutput("wr_addr", int'(wr_addr), w.addr);
                    checkOutput("wr_zero", int'(wr_zero), int'(w.zero));
                end
            end
            em = (macQ.size() > 0) && (macQ[0].cyc == cyc);
            checkOutput("mac_en", int'(mac_en), int'(em));
            if (em) begin
                m = macQ.pop_front();
                if (mac_en) begin
                    checkOutput("rd_addr_a", int'(rd_addr_a), m.a);
                    checkOutput("rd_addr_b", int'(rd_addr_b), m.b);
                    checkOutput("coef_addr", int'(coef_addr), m.coef);
                    checkOutput("mac_clr", int'(mac_clr), int'(m.clr));
                    checkOutput("mac_last", int'(mac_last), int'(m.last));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        applyStimulus(0, 1, 1, 3);
        applyStimulus(0, 1, 0, 18);
        applyStimulus(1, 1, 0, 1);
        applyStimulus(0, 1, 0, 25);

        // Back-to-back samples wrap the write pointer past slot 15.
        applyStimulus(1, 1, 0, 18 * (NMAC + MAC_LAT + 2) + 5);
        applyStimulus(0, 1, 0, 25);

        // Result held while downstream stalls, with a sample waiting.
        applyStimulus(1, 0, 0, 30);
        applyStimulus(1, 1, 0, 3);
        applyStimulus(0, 1, 0, 25);

        // Reset in the middle of the tap walk (tap 7).
        t = 0;
        while (!expIR && t < 100) begin
            applyStimulus(0, 1, 0, 1);
            t++;
        end
        checkOutput("ready_before_abort", int'(expIR), 1);
        applyStimulus(1, 1, 0, 1);
        applyStimulus(0, 1, 0, 7);
        applyStimulus(0, 1, 1, 1);
        applyStimulus(1, 1, 0, 40);
        applyStimulus(0, 1, 0, 25);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                          $urandom_range(0, 199) == 0, 1);
        end

        applyStimulus(0, 1, 0, 40);
        checkOutput("wr_queue_drained", wrQ.size(), 0);
        checkOutput("mac_queue_drained", macQ.size(), 0);
        checkOutput("accepts_seen", int'(lastAccept >= 0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
